// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared defaults, FSM state encoding and helpers for the LDPC
// decode sequencer.
//
// Contents:
//   K_DEF, L_DEF, ADDR_WIDTH_DEF, MESSAGE_WIDTH_DEF, PIPE_LAT_DEF, READ_LAT_DEF
//     default geometry and latencies
//   ITER_W     width of the iteration limit, relay and iter_count fields
//   state_t    FSM state type, with S_* constants
//   max3()     largest of three ints, used to size the shared phase timer
package ldpc_pkg;

    localparam int K_DEF             = 6;
    localparam int L_DEF             = 32;
    localparam int ADDR_WIDTH_DEF    = 5;
    localparam int MESSAGE_WIDTH_DEF = 5;
    localparam int PIPE_LAT_DEF      = 6;
    localparam int READ_LAT_DEF      = 6;

    localparam int ITER_W  = 6;
    localparam int STATE_W = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE      = 4'd0;
    localparam state_t S_CLEAR     = 4'd1;
    localparam state_t S_LOAD      = 4'd2;
    localparam state_t S_CNU       = 4'd3;
    localparam state_t S_CNU_DRAIN = 4'd4;
    localparam state_t S_VNU       = 4'd5;
    localparam state_t S_VNU_DRAIN = 4'd6;
    localparam state_t S_READ      = 4'd7;
    localparam state_t S_DONE      = 4'd8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ldpc_phase_counter.sv
// ldpc_phase_counter: up-counter 0..max_i that wraps to 0 on its terminal count.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clr_i       force the count to 0 (wins over en_i)
//   en_i        advance one step; wraps to 0 when the count equals max_i
//   max_i       terminal value; may change between phases
//   count_o     current count
//   tc_o        count_o == max_i
module ldpc_phase_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] max_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc_o    = (count_q == max_i);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ldpc_decode_sequencer.sv
// ldpc_decode_sequencer: control sequencer for a K x K block LDPC decoder.
// Loads intrinsic words into the PE memories, runs CNU/VNU iterations with
// pipeline drains, then streams the hard decisions out.
//
// Optional feature: define LDPC_SEQ_EARLY_TERM_EN to let parity_ok on the
// last VNU_DRAIN cycle end decoding early. When undefined, parity_ok is
// ignored and exactly the iteration limit runs.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   start, cfg_max_iter          begin a decode (IDLE only); iteration limit (0 acts as 1)
//   in_valid, in_data, in_ready  intrinsic input stream, accepted in LOAD
//   parity_ok                    all-checks-satisfied flag from the datapath
//   dec_reset, en, f_id, relay   PE/CNU clear, enable, phase (0 CNU / 1 VNU), iteration index
//   pe_select, load_add, int_out memory load bus, one cycle after each accepted word
//   read_add, column_select      decision readout address and column strobe
//   dec_in, out_valid, out_data  decisions in; registered output stream
//   busy, done, iter_count       status
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for start
// CLEAR       | one cycle of dec_reset
// LOAD        | accept K*K*L intrinsic words
// CNU         | check-node phase, en=1 for L cycles
// CNU_DRAIN   | CNU pipeline drain, PIPE_LAT cycles
// VNU         | variable-node phase, en=1 for L cycles
// VNU_DRAIN   | VNU pipeline drain, PIPE_LAT cycles; decides next iteration
// READ        | issue L read addresses, then wait READ_LAT cycles
// DONE        | one-cycle done pulse, iter_count valid
module ldpc_decode_sequencer
    import ldpc_pkg::*;
#(
    parameter int K             = K_DEF,
    parameter int L             = L_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int MESSAGE_WIDTH = MESSAGE_WIDTH_DEF,
    parameter int PIPE_LAT      = PIPE_LAT_DEF,
    parameter int READ_LAT      = READ_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ITER_W-1:0]        cfg_max_iter,
    input  logic                     in_valid,
    input  logic [MESSAGE_WIDTH-1:0] in_data,
    output logic                     in_ready,
    input  logic                     parity_ok,
    output logic                     dec_reset,
    output logic                     en,
    output logic                     f_id,
    output logic [ITER_W-1:0]        relay,
    output logic [K*K-1:0]           pe_select,
    output logic [ADDR_WIDTH-1:0]    load_add,
    output logic [MESSAGE_WIDTH-1:0] int_out,
    output logic [ADDR_WIDTH-1:0]    read_add,
    output logic [K-1:0]             column_select,
    input  logic [K*K-1:0]           dec_in,
    output logic                     out_valid,
    output logic [K*K-1:0]           out_data,
    output logic                     busy,
    output logic                     done,
    output logic [ITER_W-1:0]        iter_count
);

    localparam int NPE  = K * K;
    localparam int PW   = $clog2(NPE);
    localparam int PH_W = $clog2(max3(L, PIPE_LAT, READ_LAT) + 1);

    localparam logic [PH_W-1:0] PH_PHASE_MAX = PH_W'(L - 1);
    localparam logic [PH_W-1:0] PH_DRAIN_MAX = PH_W'(PIPE_LAT - 1);
    localparam logic [PH_W-1:0] PH_RDLAT_MAX = PH_W'(READ_LAT - 1);

    state_t                   state_q, state_d;
    logic [ITER_W-1:0]        limit_q, limit_d;
    logic [ITER_W-1:0]        relay_q, relay_d;
    logic [ITER_W-1:0]        iter_count_q, iter_count_d;
    logic                     rd_wait_q, rd_wait_d;
    logic [NPE-1:0]           pe_sel_q;
    logic [ADDR_WIDTH-1:0]    load_add_q;
    logic [MESSAGE_WIDTH-1:0] int_out_q;
    logic [READ_LAT-1:0]      rd_pipe_q;
    logic [NPE-1:0]           out_data_q;

    logic                  accept;
    logic                  issue;
    logic                  early_term;
    logic [ADDR_WIDTH-1:0] a_count;
    logic                  a_tc;
    logic [PW-1:0]         p_count;
    logic                  p_tc;
    logic [PH_W-1:0]       ph_count;
    logic [PH_W-1:0]       ph_max;
    logic                  ph_en;
    logic                  ph_tc;
    logic                  clr_cnt;

`ifdef LDPC_SEQ_EARLY_TERM_EN
    assign early_term = parity_ok;
`else
    logic unused_parity_ok;
    assign unused_parity_ok = parity_ok;
    assign early_term       = 1'b0;
`endif

    assign accept  = (state_q == S_LOAD) && in_valid;
    assign issue   = (state_q == S_READ) && !rd_wait_q;
    assign clr_cnt = (state_q == S_CLEAR);

    // Address counter steps every accepted word; PE counter steps on its wrap.
    ldpc_phase_counter #(.WIDTH(ADDR_WIDTH)) u_addr_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr_cnt),
        .en_i    (accept),
        .max_i   (ADDR_WIDTH'(L - 1)),
        .count_o (a_count),
        .tc_o    (a_tc)
    );

    ldpc_phase_counter #(.WIDTH(PW)) u_pe_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr_cnt),
        .en_i    (accept && a_tc),
        .max_i   (PW'(NPE - 1)),
        .count_o (p_count),
        .tc_o    (p_tc)
    );

    // One timer serves every timed phase; it wraps to 0 exactly when the
    // FSM leaves a phase, so no explicit clear is needed between phases.
    always_comb begin
        ph_max = PH_PHASE_MAX;
        if (state_q == S_CNU_DRAIN || state_q == S_VNU_DRAIN) begin
            ph_max = PH_DRAIN_MAX;
        end else if (state_q == S_READ && rd_wait_q) begin
            ph_max = PH_RDLAT_MAX;
        end
    end

    assign ph_en = (state_q == S_CNU) || (state_q == S_CNU_DRAIN) ||
                   (state_q == S_VNU) || (state_q == S_VNU_DRAIN) ||
                   (state_q == S_READ);

    ldpc_phase_counter #(.WIDTH(PH_W)) u_phase_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr_cnt),
        .en_i    (ph_en),
        .max_i   (ph_max),
        .count_o (ph_count),
        .tc_o    (ph_tc)
    );

    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        relay_d      = relay_q;
        iter_count_d = iter_count_q;
        rd_wait_d    = rd_wait_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    limit_d = (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
                    relay_d = '0;
                end
            end
            S_CLEAR: state_d = S_LOAD;
            S_LOAD: begin
                if (accept && a_tc && p_tc) state_d = S_CNU;
            end
            S_CNU: begin
                if (ph_tc) state_d = S_CNU_DRAIN;
            end
            S_CNU_DRAIN: begin
                if (ph_tc) state_d = S_VNU;
            end
            S_VNU: begin
                if (ph_tc) state_d = S_VNU_DRAIN;
            end
            S_VNU_DRAIN: begin
                if (ph_tc) begin
                    relay_d = relay_q + ITER_W'(1);
                    if ((relay_q + ITER_W'(1) == limit_q) || early_term) begin
                        state_d   = S_READ;
                        rd_wait_d = 1'b0;
                    end else begin
                        state_d = S_CNU;
                    end
                end
            end
            S_READ: begin
                if (ph_tc) begin
                    if (!rd_wait_q) begin
                        rd_wait_d = 1'b1;
                    end else begin
                        state_d      = S_DONE;
                        iter_count_d = relay_q;
                    end
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                relay_d   = '0;
                rd_wait_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            limit_q      <= '0;
            relay_q      <= '0;
            iter_count_q <= '0;
            rd_wait_q    <= 1'b0;
            pe_sel_q     <= '0;
            load_add_q   <= '0;
            int_out_q    <= '0;
            rd_pipe_q    <= '0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            limit_q      <= limit_d;
            relay_q      <= relay_d;
            iter_count_q <= iter_count_d;
            rd_wait_q    <= rd_wait_d;
            pe_sel_q     <= accept ? ({{(NPE-1){1'b0}}, 1'b1} << p_count) : '0;
            load_add_q   <= accept ? a_count : '0;
            int_out_q    <= accept ? in_data : '0;
            rd_pipe_q    <= {rd_pipe_q[READ_LAT-2:0], issue};
            // dec_in is captured one cycle before the valid bit reaches the end
            // of the pipe so that out_valid and out_data come from registers.
            out_data_q   <= rd_pipe_q[READ_LAT-2] ? dec_in : '0;
        end
    end

    assign in_ready      = (state_q == S_LOAD);
    assign dec_reset     = (state_q == S_CLEAR);
    assign en            = (state_q == S_CNU) || (state_q == S_VNU);
    assign f_id          = (state_q == S_VNU) || (state_q == S_VNU_DRAIN);
    assign relay         = relay_q;
    assign pe_select     = pe_sel_q;
    assign load_add      = load_add_q;
    assign int_out       = int_out_q;
    assign read_add      = issue ? ADDR_WIDTH'(ph_count) : '0;
    assign column_select = {K{issue}};
    assign out_valid     = rd_pipe_q[READ_LAT-1];
    assign out_data      = out_data_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign iter_count    = iter_count_q;

endmodule

// File: tb/tb_ldpc_decode_sequencer.sv
module tb_ldpc_decode_sequencer;

    localparam int K        = 6;
    localparam int L        = 32;
    localparam int AW       = 5;
    localparam int MW       = 5;
    localparam int PIPE_LAT = 6;
    localparam int READ_LAT = 6;
    localparam int NPE      = K * K;
    localparam int ITER     = 2 * (L + PIPE_LAT);
    localparam int NEVER    = 1 << 30;
    localparam int OUTW     = 4 + 6 + NPE + AW + MW + AW + K + 1 + NPE + 2 + 6;
`ifdef LDPC_SEQ_EARLY_TERM_EN
    localparam int EARLY_EXP = 3;
`else
    localparam int EARLY_EXP = 10;
`endif

    logic           clk = 1'b0;
    logic           reset, start, in_valid, parity_ok;
    logic [5:0]     cfg_max_iter;
    logic [MW-1:0]  in_data;
    logic           in_ready, dec_reset, en, f_id, out_valid, busy, done;
    logic [5:0]     relay, iter_count;
    logic [NPE-1:0] pe_select, dec_in, out_data;
    logic [AW-1:0]  load_add, read_add;
    logic [MW-1:0]  int_out;
    logic [K-1:0]   column_select;

    ldpc_decode_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .cfg_max_iter(cfg_max_iter),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .parity_ok(parity_ok), .dec_reset(dec_reset), .en(en), .f_id(f_id),
        .relay(relay), .pe_select(pe_select), .load_add(load_add),
        .int_out(int_out), .read_add(read_add), .column_select(column_select),
        .dec_in(dec_in), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        int            p;
        int            a;
        logic [MW-1:0] d;
    } load_t;
    typedef struct {
        int             t;
        logic [NPE-1:0] d;
    } rd_t;
    load_t load_q[$];
    rd_t   rd_q[$];

    function automatic logic [NPE-1:0] pat(input int n);
        logic [31:0] h;
        h = n * 32'h9E37_79B1;
        return {h[3:0], h ^ 32'h5A5A_0F0F};
    endfunction

    function automatic logic [OUTW-1:0] all_outs();
        return {in_ready, dec_reset, en, f_id, relay, pe_select, load_add, int_out,
                read_add, column_select, out_valid, out_data, busy, done, iter_count};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        dec_in = pat(cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_total++;
        if (all_outs() !== '0) $display("FAIL reset_outputs: got %h want 0", all_outs());
        else n_pass++;
        reset = 1'b0;
        step();
        n_total++;
        if (all_outs() !== '0) $display("FAIL idle_outputs: got %h want 0", all_outs());
        else n_pass++;
    endtask

    task automatic test_load(input int cfg, input bit gaps, input int nwords);
        int             w = 0;
        int             cycles = 0;
        int             ready_cycles = 0;
        bit             v;
        load_t          e, g;
        logic [NPE-1:0] eo;
        cfg_max_iter = 6'(cfg);
        start = 1'b1;
        step();
        start = 1'b0;
        n_total++;
        if (dec_reset !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL clear_cycle: dec_reset=%b busy=%b in_ready=%b want 1 1 0",
                     dec_reset, busy, in_ready);
        else n_pass++;
        step();
        while (w < nwords && cycles < 6000) begin
            cycles++;
            if (in_ready === 1'b1) ready_cycles++;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid = v;
            in_data  = MW'($urandom);
            if (v) begin
                e.p = w / L;
                e.a = w % L;
                e.d = in_data;
                load_q.push_back(e);
                w++;
            end
            step();
            in_valid = 1'b0;
            n_total++;
            if (v) begin
                g = load_q.pop_front();
                eo = '0;
                eo[g.p] = 1'b1;
                if (pe_select !== eo || load_add !== AW'(g.a) || int_out !== g.d)
                    $display("FAIL load_word %0d: pe_select=%h load_add=%0d int_out=%0d want %h %0d %0d",
                             w - 1, pe_select, load_add, int_out, eo, g.a, g.d);
                else n_pass++;
            end else begin
                if (pe_select !== '0)
                    $display("FAIL load_gap: pe_select=%h want 0", pe_select);
                else n_pass++;
            end
        end
        n_total++;
        if (w != nwords) $display("FAIL load_count: accepted %0d want %0d", w, nwords);
        else n_pass++;
        if (nwords == NPE * L) begin
            n_total++;
            if (in_ready !== 1'b0 || en !== 1'b1 || ready_cycles != cycles)
                $display("FAIL load_exit: in_ready=%b en=%b ready_cycles=%0d want 0 1 %0d",
                         in_ready, en, ready_cycles, cycles);
            else n_pass++;
            if (!gaps) begin
                n_total++;
                if (cycles != NPE * L)
                    $display("FAIL load_length: %0d cycles want %0d", cycles, NPE * L);
                else n_pass++;
            end
        end
    endtask

    task automatic test_iterations(input int n_iter, input int parity_from, input int start_at);
        int   o;
        logic exp_en, exp_f;
        for (int c = 0; c < n_iter * ITER; c++) begin
            parity_ok = (c >= parity_from);
            start     = (c == start_at);
            o         = c % ITER;
            exp_en    = (o < L) || (o >= L + PIPE_LAT && o < 2 * L + PIPE_LAT);
            exp_f     = (o >= L + PIPE_LAT);
            n_total++;
            if (en !== exp_en || f_id !== exp_f || relay !== 6'(c / ITER) ||
                busy !== 1'b1 || column_select !== '0)
                $display("FAIL iter_c%0d: en=%b f_id=%b relay=%0d busy=%b csel=%h want %b %b %0d 1 0",
                         c, en, f_id, relay, busy, column_select, exp_en, exp_f, c / ITER);
            else n_pass++;
            step();
        end
        parity_ok = 1'b0;
        start     = 1'b0;
        n_total++;
        if (column_select !== {K{1'b1}} || read_add !== '0 || relay !== 6'(n_iter) || en !== 1'b0)
            $display("FAIL read_entry: csel=%h read_add=%0d relay=%0d en=%b want 3f 0 %0d 0",
                     column_select, read_add, relay, en, n_iter);
        else n_pass++;
    endtask

    task automatic test_readout(input int n_iter);
        int  issues = 0;
        int  valids = 0;
        int  dones  = 0;
        rd_t e, g;
        for (int c = 0; c < L + READ_LAT + 4; c++) begin
            if (column_select === {K{1'b1}}) begin
                n_total++;
                if (read_add !== AW'(issues))
                    $display("FAIL read_add: got %0d want %0d", read_add, issues);
                else n_pass++;
                e.t = cyc + READ_LAT;
                e.d = pat(cyc + READ_LAT - 1);
                rd_q.push_back(e);
                issues++;
            end
            if (out_valid === 1'b1) begin
                valids++;
                n_total++;
                if (rd_q.size() == 0) begin
                    $display("FAIL out_unexpected: out_valid at cycle %0d with nothing issued", cyc);
                end else begin
                    g = rd_q.pop_front();
                    if (cyc != g.t || out_data !== g.d)
                        $display("FAIL out_word: cycle %0d data %h want cycle %0d data %h",
                                 cyc, out_data, g.t, g.d);
                    else n_pass++;
                end
            end
            if (done === 1'b1) begin
                dones++;
                n_total++;
                if (iter_count !== 6'(n_iter) || busy !== 1'b1)
                    $display("FAIL done_iter_count: got %0d busy=%b want %0d 1", iter_count, busy, n_iter);
                else n_pass++;
            end
            step();
        end
        n_total++;
        if (issues != L || valids != L || dones != 1 || busy !== 1'b0 || rd_q.size() != 0)
            $display("FAIL readout_totals: issues=%0d valids=%0d dones=%0d busy=%b want %0d %0d 1 0",
                     issues, valids, dones, busy, L, L);
        else n_pass++;
        rd_q.delete();
    endtask

    task automatic test_back_to_back();
        test_load(2, 1'b0, NPE * L);
        test_iterations(2, NEVER, -1);
        test_readout(2);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        test_load(2, 1'b0, 500);
        reset = 1'b1;
        step();
        n_total++;
        if (all_outs() !== '0) $display("FAIL reset_mid_load: got %h want 0", all_outs());
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || busy === 1'b1) bad++;
            step();
        end
        n_total++;
        if (bad != 0) $display("FAIL post_reset_idle: %0d active cycles want 0", bad);
        else n_pass++;
        test_load(2, 1'b1, NPE * L);
        for (int i = 0; i < 40; i++) step();
        reset = 1'b1;
        step();
        n_total++;
        if (all_outs() !== '0) $display("FAIL reset_mid_iter: got %h want 0", all_outs());
        else n_pass++;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1 || busy === 1'b1) bad++;
            step();
        end
        n_total++;
        if (bad != 0) $display("FAIL no_done_after_reset: %0d active cycles want 0", bad);
        else n_pass++;
        load_q.delete();
    endtask

    task automatic test_min_iter();
        int bad = 0;
        test_load(0, 1'b0, NPE * L);
        test_iterations(1, NEVER, 5);
        test_readout(1);
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) bad++;
            step();
        end
        n_total++;
        if (bad != 0) $display("FAIL start_while_busy: busy %0d cycles after done want 0", bad);
        else n_pass++;
    endtask

    task automatic test_early_term();
        test_load(10, 1'b1, NPE * L);
        test_iterations(EARLY_EXP, 2 * ITER, -1);
        test_readout(EARLY_EXP);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        parity_ok    = 1'b0;
        cfg_max_iter = '0;
        dec_in       = pat(0);
        test_reset();
        test_back_to_back();
        test_reset_mid();
        test_min_iter();
        test_early_term();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
